// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state, opcode and datapath select codes shared by the multi-cycle control path and ALUControl.
package cpu_ctrl_pkg;
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_WB_R      = 4'd4;
  localparam logic [3:0] S_EXEC_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD    = 4'd6;
  localparam logic [3:0] S_WB_LD     = 4'd7;
  localparam logic [3:0] S_MEM_WR    = 4'd8;
  localparam logic [3:0] S_WB_I      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;
  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_CONST2 = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps the current control state (and memory handshake) to the datapath control word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_CONST2;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALU_SRC_B_IMM_SH;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_WB_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle CPU control sequencer with retired-instruction counter and sticky illegal-opcode trap.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  logic [3:0] state, state_d;
  logic       retire;
  logic       zero_unused;
  ctrl_t      ctrl;
  ctrl_decode u_decode (
    .state    (state),
    .mem_ready(mem_ready),
    .ctrl     (ctrl)
  );
  assign {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_rd, mem_wr,
          reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op} = ctrl;
  // zero is consumed by the PC-write gate in the datapath, not here
  assign zero_unused = zero;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = opcode == OP_R    ? S_EXEC_R :
                             (opcode == OP_LW || opcode == OP_SW || opcode == OP_ADDI) ? S_EXEC_ADDR :
                             opcode == OP_BEQ  ? S_BRANCH :
                             opcode == OP_J    ? S_JUMP : S_TRAP;
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_ADDR: state_d = opcode == OP_LW ? S_MEM_RD : opcode == OP_SW ? S_MEM_WR : S_WB_I;
      S_MEM_RD:    state_d = mem_ready ? S_WB_LD : S_MEM_RD;
      S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_LD, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end
  // a FETCH wait loop or the first fetch after reset is not a retirement
  assign retire = state_d == S_FETCH && state != S_FETCH && state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
      if (state_d == S_TRAP) illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed vector table, reset/trap/wrap sequences and randomized instruction streams vs a per-opcode phase script.
module tb_multicycle_ctrl_fsm;
  localparam logic [15:0] PW = 16'h8000, PWC = 16'h4000, PS_AO = 16'h1000, PS_J = 16'h2000;
  localparam logic [15:0] IRW = 16'h0800, IOD = 16'h0400, MRD = 16'h0200, MWR = 16'h0100;
  localparam logic [15:0] RW = 16'h0080, RD = 16'h0040, M2R = 16'h0020, ASA = 16'h0010;
  localparam logic [15:0] B_C2 = 16'h0004, B_IMM = 16'h0008, B_SH = 16'h000c, A_SUB = 16'h0001, A_F = 16'h0002;
  localparam logic [15:0] C_FW = MRD | B_C2, C_FG = C_FW | IRW | PW, C_DEC = B_SH;
  localparam logic [15:0] C_EXR = ASA | A_F, C_WBR = RW | RD, C_EXA = ASA | B_IMM;
  localparam logic [15:0] C_MRD = MRD | IOD, C_WBL = RW | M2R, C_MWR = MWR | IOD, C_WBI = RW;
  localparam logic [15:0] C_BR = ASA | A_SUB | PWC | PS_AO, C_JMP = PW | PS_J, C_0 = 16'h0000;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic pc_write, pc_write_cond, ir_write, i_or_d, mem_rd, mem_wr, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] retired;
  logic [15:0] act;
  int tests = 0, fails = 0, mcnt = 0;
  typedef struct {
    logic        mr;
    logic [2:0]  op;
    logic [15:0] cw;
    logic [3:0]  ret;
    string       name;
  } vec_t;
  vec_t vecs[16];
  always #5 clk = ~clk;
  multicycle_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .retired(retired)
  );
  assign act = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_rd, mem_wr,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
  function automatic vec_t mk(input logic mr, input logic [2:0] op, input logic [15:0] cw, input logic [3:0] ret, input string name);
    mk.mr = mr; mk.op = op; mk.cw = cw; mk.ret = ret; mk.name = name;
  endfunction
  task automatic check(input logic [15:0] ecw, input logic [3:0] eret, input logic eill, input string name);
    tests++;
    if (act !== ecw || retired !== eret || illegal !== eill) begin
      fails++;
      $display("FAIL %s: got cw=%h retired=%0d illegal=%b, expected cw=%h retired=%0d illegal=%b",
               name, act, retired, illegal, ecw, eret, eill);
    end
  endtask
  task automatic step(input logic mr, input logic [2:0] op, input logic [15:0] ecw, input logic [3:0] eret, input logic eill, input string name);
    @(negedge clk);
    mem_ready = mr;
    opcode = op;
    zero = 1'($urandom);
    #1 check(ecw, eret, eill, name);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check(C_0, 4'd0, 1'b0, "reset_asserted");
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    #1 check(C_0, 4'd0, 1'b0, "idle_after_reset");
  endtask
  // one instruction as the spec's per-opcode phase list; opcode is only meaningful in DECODE/EXEC_ADDR
  task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
    logic [3:0] r;
    r = 4'(mcnt);
    for (int i = 0; i < fw; i++) step(1'b0, 3'($urandom), C_FW, r, 1'b0, "fetch_wait");
    step(1'b1, 3'($urandom), C_FG, r, 1'b0, "fetch");
    step(1'($urandom), op, C_DEC, r, 1'b0, "decode");
    case (op)
      3'd0: begin
        step(1'($urandom), 3'($urandom), C_EXR, r, 1'b0, "exec_r");
        step(1'($urandom), 3'($urandom), C_WBR, r, 1'b0, "wb_r");
      end
      3'd1, 3'd2, 3'd4: begin
        step(1'($urandom), op, C_EXA, r, 1'b0, "exec_addr");
        if (op == 3'd4) step(1'($urandom), 3'($urandom), C_WBI, r, 1'b0, "wb_i");
        else begin
          for (int i = 0; i < mw; i++) step(1'b0, 3'($urandom), op == 3'd1 ? C_MRD : C_MWR, r, 1'b0, "mem_wait");
          step(1'b1, 3'($urandom), op == 3'd1 ? C_MRD : C_MWR, r, 1'b0, "mem_done");
          if (op == 3'd1) step(1'($urandom), 3'($urandom), C_WBL, r, 1'b0, "wb_ld");
        end
      end
      3'd3: step(1'($urandom), 3'($urandom), C_BR, r, 1'b0, "branch");
      default: step(1'($urandom), 3'($urandom), C_JMP, r, 1'b0, "jump");
    endcase
    mcnt++;
  endtask
  initial begin
    vecs[0]  = mk(1'b1, 3'd6, C_FG,  4'd0, "r_fetch");
    vecs[1]  = mk(1'b1, 3'd0, C_DEC, 4'd0, "r_decode");
    vecs[2]  = mk(1'b0, 3'd7, C_EXR, 4'd0, "r_exec");
    vecs[3]  = mk(1'b1, 3'd7, C_WBR, 4'd0, "r_wb");
    vecs[4]  = mk(1'b1, 3'd3, C_FG,  4'd1, "beq_fetch");
    vecs[5]  = mk(1'b1, 3'd3, C_DEC, 4'd1, "beq_decode");
    vecs[6]  = mk(1'b1, 3'd3, C_BR,  4'd1, "beq_branch");
    vecs[7]  = mk(1'b1, 3'd1, C_FG,  4'd2, "lw_fetch");
    vecs[8]  = mk(1'b1, 3'd1, C_DEC, 4'd2, "lw_decode");
    vecs[9]  = mk(1'b1, 3'd1, C_EXA, 4'd2, "lw_exec");
    vecs[10] = mk(1'b0, 3'd6, C_MRD, 4'd2, "lw_wait1");
    vecs[11] = mk(1'b0, 3'd2, C_MRD, 4'd2, "lw_wait2");
    vecs[12] = mk(1'b0, 3'd5, C_MRD, 4'd2, "lw_wait3");
    vecs[13] = mk(1'b1, 3'd0, C_MRD, 4'd2, "lw_mem_done");
    vecs[14] = mk(1'b0, 3'd0, C_WBL, 4'd2, "lw_wb");
    vecs[15] = mk(1'b0, 3'd0, C_FW,  4'd3, "next_fetch_wait");
    #3 check(C_0, 4'd0, 1'b0, "power_on_reset");
    do_reset();
    foreach (vecs[i]) step(vecs[i].mr, vecs[i].op, vecs[i].cw, vecs[i].ret, 1'b0, vecs[i].name);
    do_reset();
    run_instr(3'd5, 0, 0);
    step(1'b0, 3'd0, C_FW, 4'd1, 1'b0, "fetch_before_reset");
    #2 rst_n = 1'b0;
    #1 check(C_0, 4'd0, 1'b0, "reset_mid_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    #1 check(C_0, 4'd0, 1'b0, "idle_after_mid_reset");
    run_instr(3'd0, 0, 0);
    do_reset();
    run_instr(3'd5, 1, 0);
    step(1'b1, 3'($urandom), C_FG, 4'd1, 1'b0, "trap_fetch");
    step(1'b1, 3'd7, C_DEC, 4'd1, 1'b0, "trap_decode");
    for (int i = 0; i < 20; i++) step(1'($urandom), 3'($urandom), C_0, 4'd1, 1'b1, "trap_hold");
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(3'd5, 0, 0);
    step(1'b0, 3'd0, C_FW, 4'd0, 1'b0, "counter_wrap");
    do_reset();
    for (int i = 0; i < 150; i++) run_instr(3'($urandom_range(0, 5)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    step(1'b0, 3'd0, C_FW, 4'(mcnt), 1'b0, "random_final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
